// File: rtl/uart_flit_deframer.sv
// Receive-side deframer: hunts for a sync byte, gathers a payload flit MSB-first,
// verifies an XOR checksum and holds the flit in a one-entry valid/ready buffer.
module uart_flit_deframer #(
    parameter int          FLIT_BYTES     = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_valid,
    output logic [8*FLIT_BYTES-1:0] flit_data,
    output logic                    flit_valid,
    input  logic                    flit_ready,
    output logic                    crc_err,
    output logic                    timeout_err,
    output logic                    overflow,
    output logic                    busy
);
    localparam int FLIT_WIDTH = 8 * FLIT_BYTES;
    localparam int CNT_W      = $clog2(FLIT_BYTES + 1);
    localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [TMR_W-1:0]        r_timer;
    logic [FLIT_WIDTH-1:0]   r_shift;
    logic [7:0]              r_csum;
    logic [FLIT_WIDTH-1:0]   r_flit_data;
    logic                    r_flit_valid;
    logic                    r_crc_err;
    logic                    r_timeout_err;
    logic                    r_overflow;
    logic                    r_busy;

    logic                    w_frame_start;
    logic                    w_shift_en;
    logic                    w_csum_ok;
    logic                    w_csum_bad;
    logic                    w_timeout;
    logic                    w_expire;
    logic                    w_buf_free;
    logic                    w_load;
    logic                    w_overflow;

    // A strobe always wins over expiry, so expiry is only acted on in strobe-less cycles.
    assign w_expire = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_csum_ok     = 1'b0;
        w_csum_bad    = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_data_valid && rx_data == SYNC_BYTE) begin
                    w_state_next  = S_PAYLOAD;
                    w_frame_start = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (rx_data_valid) begin
                    w_shift_en = 1'b1;
                    if (r_byte_cnt == CNT_W'(FLIT_BYTES - 1)) begin
                        w_state_next = S_CHECK;
                    end
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (rx_data_valid) begin
                    w_state_next = S_IDLE;
                    if (rx_data == r_csum) begin
                        w_csum_ok = 1'b1;
                    end else begin
                        w_csum_bad = 1'b1;
                    end
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Buffer is free if empty or being drained in this very cycle.
    assign w_buf_free = !r_flit_valid || flit_ready;
    assign w_load     = w_csum_ok && w_buf_free;
    assign w_overflow = w_csum_ok && !w_buf_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt    <= '0;
            r_timer       <= '0;
            r_shift       <= '0;
            r_csum        <= '0;
            r_flit_data   <= '0;
            r_flit_valid  <= 1'b0;
            r_crc_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (r_state == S_IDLE || rx_data_valid || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_frame_start) begin
                r_byte_cnt <= '0;
                r_csum     <= '0;
            end else if (w_shift_en) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_csum     <= r_csum ^ rx_data;
                r_shift    <= (r_shift << 8) | FLIT_WIDTH'(rx_data);
            end

            if (w_load) begin
                r_flit_data  <= r_shift;
                r_flit_valid <= 1'b1;
            end else if (flit_ready) begin
                r_flit_valid <= 1'b0;
            end

            r_crc_err     <= w_csum_bad;
            r_timeout_err <= w_timeout;
            r_overflow    <= w_overflow;
            r_busy        <= (w_state_next != S_IDLE);
        end
    end

    assign flit_data   = r_flit_data;
    assign flit_valid  = r_flit_valid;
    assign crc_err     = r_crc_err;
    assign timeout_err = r_timeout_err;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule
